// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide, one radix-2 step per cycle, fixed 33-cycle latency.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_acc_nx, w_sh_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  assign w_a_neg = op[0] & op_a[WIDTH-1];
  assign w_b_neg = op[0] & op_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -op_a : op_a;
  assign w_b_mag = w_b_neg ? -op_b : op_b;

  // r_m is the addend (|a|) for multiply or the divisor (|b|) for divide;
  // r_sh is the multiplier being consumed or the dividend becoming the quotient.
  always_comb begin
    w_sum    = {1'b0, r_acc} + {1'b0, r_m};
    w_rem_sh = {r_acc, r_sh[WIDTH-1]};
    w_diff   = w_rem_sh[WIDTH-1:0] - r_m;
    w_acc_nx = r_acc;
    w_sh_nx  = r_sh;
    if (r_is_div) begin
      if (w_rem_sh >= {1'b0, r_m}) begin
        w_acc_nx = w_diff;
        w_sh_nx  = {r_sh[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nx = w_rem_sh[WIDTH-1:0];
        w_sh_nx  = {r_sh[WIDTH-2:0], 1'b0};
      end
    end else if (r_sh[0]) begin
      {w_acc_nx, w_sh_nx} = {w_sum, r_sh[WIDTH-1:1]};
    end else begin
      {w_acc_nx, w_sh_nx} = {1'b0, r_acc, r_sh[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_prod   = {w_acc_nx, w_sh_nx};
    w_res_hi = '0;
    w_res_lo = '0;
    if (!r_is_div) begin
      {w_res_hi, w_res_lo} = r_neg_q ? -w_prod : w_prod;
    end else if (r_m == '0) begin
      w_res_hi = r_a_raw;
      w_res_lo = '1;
    end else begin
      w_res_lo = r_neg_q ? -w_sh_nx : w_sh_nx;
      w_res_hi = r_neg_r ? -w_acc_nx : w_acc_nx;
    end
  end

  // The result is registered on the edge into FIN so it is visible while done is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a_raw  <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_a_raw  <= op_a;
            r_acc    <= '0;
            r_m      <= op[1] ? w_b_mag : w_a_mag;
            r_sh     <= op[1] ? w_a_mag : w_b_mag;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nx;
          r_sh  <= w_sh_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_FIN;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_FIN);

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed and random MULT/DIV ops scored
// against a plain-arithmetic reference model, plus MTHI/MTLO and control cases.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (o)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: p = 64'(sa * sb);
      2'b10: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: p = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
    endcase
    return p;
  endfunction

  // driver: disturb 0=none, 1=mtlo during CALC, 2=start during CALC
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int disturb, input bit with_mtlo);
    int good_cyc;
    logic [63:0] exp;
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    mtlo = with_mtlo; wdata = 32'hDEADBEEF;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    op_a = $urandom; op_b = $urandom;
    good_cyc = 0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b1 && done === 1'b0 && {hi, lo} === {m_hi, m_lo}) good_cyc++;
      if (i == 5) begin
        if (disturb == 1) begin mtlo = 1'b1; wdata = 32'h0BADF00D; end
        if (disturb == 2) begin start = 1'b1; op = $urandom_range(0, 3); end
      end
      if (i == 6) begin mtlo = 1'b0; start = 1'b0; end
    end
    check({tag, "_busy_window"}, 64'(good_cyc), 64'd32);
    @(negedge clk);
    check({tag, "_done"}, {62'b0, done, busy}, {62'b0, 1'b1, 1'b0});
    check({tag, "_q_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
    check({tag, "_result"}, {hi, lo}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(negedge clk);
    check({tag, "_after"}, {hi, lo, 30'b0, done, busy}, {m_hi, m_lo, 32'b0});
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int pulses;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {hi, lo, 30'b0, done, busy}, 96'b0);

    // MTHI alone, MTLO alone, then both together
    mthi = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0; m_hi = 32'hA5A5A5A5;
    check("mthi", {hi, lo}, {m_hi, m_lo});
    mtlo = 1'b1; wdata = 32'h5A5A0001;
    @(negedge clk);
    mtlo = 1'b0; m_lo = 32'h5A5A0001;
    check("mtlo", {hi, lo}, {m_hi, m_lo});
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h13572468;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; m_hi = 32'h13572468; m_lo = 32'h13572468;
    check("mthi_mtlo", {hi, lo}, {m_hi, m_lo});

    // reset mid-CALC aborts the multiply
    start = 1'b1; op = 2'b00; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_hi = '0; m_lo = '0;
    check("reset_mid_calc", {hi, lo, 30'b0, done, busy}, 96'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
      @(negedge clk);
    end
    check("no_done_after_reset", 64'(pulses), 64'd0);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 0, 0);
    check("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_small", 2'b10, 32'd100, 32'd7, 0, 0);
    check("divu_small_const", {hi, lo}, {32'd2, 32'd14});
    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
    run_op("divu_zero", 2'b10, 32'h12345678, 32'd0, 0, 0);
    check("divu_zero_const", {hi, lo}, 64'h12345678_FFFFFFFF);
    run_op("div_zero_neg", 2'b11, 32'h87654321, 32'd0, 0, 0);

    run_op("mtlo_in_calc", 2'b01, 32'h00012345, 32'hFFFF0003, 1, 0);
    run_op("start_with_mtlo", 2'b10, 32'd1000, 32'd33, 0, 1);
    run_op("start_in_calc", 2'b00, 32'h00ABCDEF, 32'h00001234, 2, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    check("no_queued_start", 64'(pulses), 64'd0);

    // random operations
    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op("rand", ro, ra, rb, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the MIPS datapath; owns the HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU in 32 iterations and supports MTHI/MTLO writes.
- Its `hi`/`lo` outputs feed the 32-bit 2:1 writeback select mux, which picks HI or LO for MFHI/MFLO.
- `busy` drives the pipeline stall logic.

Parameters:
- WIDTH, 32, operand and HI/LO width; the unit is verified only at 32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
- op_a  input  WIDTH  rs operand (multiplicand / dividend)
- op_b  input  WIDTH  rt operand (multiplier / divisor)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in progress; the pipeline must stall MFHI/MFLO/MDU ops
- done  output  1  one-cycle pulse when HI/LO are updated by an operation

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-low.
  - While rst_n=0 at a rising edge: state=IDLE, hi=0, lo=0, busy=0, done=0, and all internal registers are cleared.
  - A reset mid-operation aborts the operation; no HI/LO update occurs.
- State machine:
  - IDLE, busy=0:
    - start=1 latches op, |op_a| and |op_b| (absolute values for signed ops, raw values otherwise), plus the result sign flags.
    - Clears the iteration counter and goes to CALC.
  - CALC, busy=1:
    - One radix-2 step per cycle, for 32 cycles.
    - Counter 0..31; on count 31 go to FIN.
  - FIN, busy=0:
    - Applies the sign correction and writes hi/lo.
    - done=1 for this cycle only, then goes to IDLE.
  - FIN does not accept start; the earliest next start is sampled in the cycle after FIN.
- Latency:
  - start sampled at edge N.
  - busy=1 for cycles N+1..N+32.
  - hi/lo updated and done=1 in cycle N+33.
  - Fixed latency, independent of operand values.
- Multiply:
  - Shift-add on the 64-bit product {P_hi, P_lo}; unsigned magnitudes.
  - Signed: negate the 64-bit product if sign(a) XOR sign(b).
  - hi=product[63:32], lo=product[31:0].
- Divide:
  - Restoring division on magnitudes: lo=quotient, hi=remainder.
  - Signed: quotient is negated if the signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - Divisor zero (any divide op): hi=op_a as latched (original dividend), lo=32'hFFFFFFFF. Still takes the full 33 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
- MTHI/MTLO:
  - Honoured only in IDLE. The write takes effect at that edge and is visible the next cycle.
  - mthi and mtlo together write both registers.
  - start and mthi/mtlo in the same IDLE cycle: start wins and the writes are dropped.
  - mthi/mtlo during CALC/FIN are ignored.
- Outputs and operands:
  - hi/lo hold their values outside FIN, an MTHI/MTLO write and reset; intermediate values never appear on hi/lo.
  - start during CALC/FIN is ignored and does not queue.
  - op_a/op_b may change after the start cycle without effect.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-CALC of a MULTU → after release hi=0, lo=0, busy=0, done=0, with no done pulse later.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at edge N → busy high cycles N+1..N+32; cycle N+33 done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT op_a=0xFFFFFFFD (−3), op_b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV op_a=0xFFFFFFF9 (−7), op_b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 → lo=14, hi=2.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x12345678/0 → hi=0x12345678, lo=0xFFFFFFFF, still 33-cycle latency.
- Control-priority cases:
  - IDLE, mthi=1, wdata=0xA5A5A5A5 → hi=0xA5A5A5A5 next cycle, lo unchanged.
  - mtlo during CALC → ignored.
  - start together with mtlo in IDLE → mtlo dropped and the operation result written.
  - start pulsed during CALC → no second operation.
